// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-wide data memory.
// Sub-word stores use read-modify-write; every response is a one-cycle pulse.
module load_store_unit #(
    parameter int ADDR_BITS = 14
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output logic        mem_we
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE_RD,
        STORE_WR,
        RESP
    } state_t;

    state_t      state_q;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;
    logic        err_q;

    logic        req_fault;
    logic        oor;
    logic        mis;
    logic        ill;
    logic [31:0] lane_data;
    logic [31:0] load_ext;
    logic [31:0] merged;

    always_comb begin
        oor = |req_addr[31:ADDR_BITS];
        mis = (req_funct3[1:0] == 2'd1 && req_addr[0])
            || (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'b00);
        if (req_we) begin
            ill = req_funct3 > 3'd2;
        end else begin
            ill = req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11;
        end
        req_fault = oor || mis || ill;
    end

    always_comb begin
        lane_data = mem_data_out >> {lane_q, 3'b000};
        unique case (f3_q)
            3'd0: load_ext = {{24{lane_data[7]}}, lane_data[7:0]};
            3'd1: load_ext = {{16{lane_data[15]}}, lane_data[15:0]};
            3'd4: load_ext = {24'h0, lane_data[7:0]};
            3'd5: load_ext = {16'h0, lane_data[15:0]};
            default: load_ext = mem_data_out;
        endcase
    end

    always_comb begin
        merged = mem_data_out;
        if (f3_q[0]) begin
            if (lane_q[1]) merged[31:16] = wdata_q;
            else           merged[15:0]  = wdata_q;
        end else begin
            unique case (lane_q)
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 32'h0;
            rsp_error   <= 1'b0;
            mem_we      <= 1'b0;
            mem_address <= 32'h0;
            mem_data_in <= 32'h0;
            f3_q        <= 3'd0;
            lane_q      <= 2'd0;
            wdata_q     <= 16'h0;
            err_q       <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            rsp_valid <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready   <= 1'b0;
                        f3_q        <= req_funct3;
                        lane_q      <= req_addr[1:0];
                        wdata_q     <= req_wdata[15:0];
                        err_q       <= req_fault;
                        mem_address <= {{(32-ADDR_BITS){1'b0}},
                                        req_addr[ADDR_BITS-1:2], 2'b00};
                        // Faults idle through the LOAD slot so that
                        // loads, SW and errors share one latency.
                        if (req_fault || !req_we) begin
                            state_q <= LOAD;
                        end else if (req_funct3 == 3'd2) begin
                            state_q     <= STORE_WR;
                            mem_we      <= 1'b1;
                            mem_data_in <= req_wdata;
                        end else begin
                            state_q <= STORE_RD;
                        end
                    end
                end
                LOAD: begin
                    rsp_rdata <= err_q ? 32'h0 : load_ext;
                    rsp_error <= err_q;
                    rsp_valid <= 1'b1;
                    state_q   <= RESP;
                end
                STORE_RD: begin
                    mem_data_in <= merged;
                    mem_we      <= 1'b1;
                    state_q     <= STORE_WR;
                end
                STORE_WR: begin
                    rsp_rdata <= 32'h0;
                    rsp_error <= 1'b0;
                    rsp_valid <= 1'b1;
                    state_q   <= RESP;
                end
                RESP: begin
                    req_ready <= 1'b1;
                    state_q   <= IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

endmodule
